// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants and the receiver state encoding.
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte stream: valid/ready handshake plus framing-error and overrun pulses.
interface uart_rx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] data;
    logic                      valid;
    logic                      ready;
    logic                      frame_err;
    logic                      overrun;

    modport master (
        output data,
        output valid,
        output frame_err,
        output overrun,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  frame_err,
        input  overrun,
        output ready
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input, reset to RST_VAL.
module uart_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta <= RST_VAL;
            o_q  <= RST_VAL;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8/N/1 UART receiver with mid-bit sampling and a one-byte holding register.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling (decisions one cycle later).
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | line idle, waiting for rx_s to fall
// ST_START     | timing to mid start bit; a high sample is a false start
// ST_DATA      | sampling 8 data bits, LSB first
// ST_STOP      | timing to mid stop bit; low sample is a framing error
// ST_WAIT_IDLE | after a framing error, wait for the line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 250000,
    parameter int BAUD     = 9600
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_rx,
    uart_rx_if.master rx_bus
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;

`ifdef UART_RX_MAJORITY_EN
    localparam int MIN_CPB    = 8;
    localparam int START_LOAD = HALF_BIT;
`else
    localparam int MIN_CPB    = 4;
    localparam int START_LOAD = HALF_BIT - 1;
`endif

    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(START_LOAD);
    localparam logic [CNT_W-1:0] CNT_BIT   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_IDX  = 3'(UART_DATA_BITS - 1);

    if (CLKS_PER_BIT < MIN_CPB) begin : g_cfg_check
        $error("uart_rx: CLKS_PER_BIT=%0d is below the minimum of %0d", CLKS_PER_BIT, MIN_CPB);
    end

    logic rx_s;
    logic samp;

    uart_rx_sync #(.RST_VAL(UART_IDLE_LEVEL)) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_rx),
        .o_q     (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // Delayed copies let the vote use point-1, point and point+1.
    logic rx_d1;
    logic rx_d2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_d1 <= UART_IDLE_LEVEL;
            rx_d2 <= UART_IDLE_LEVEL;
        end else begin
            rx_d1 <= rx_s;
            rx_d2 <= rx_d1;
        end
    end

    assign samp = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
`else
    assign samp = rx_s;
`endif

    uart_rx_state_t            state, state_nx;
    logic [CNT_W-1:0]          cnt, cnt_nx;
    logic [2:0]                bit_idx, idx_nx;
    logic [UART_DATA_BITS-1:0] shift_q, shift_nx;
    logic                      done_ok, done_ok_nx;
    logic                      done_err, done_err_nx;
    logic                      tc;

    assign tc = (cnt == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift_q  <= '0;
            done_ok  <= 1'b0;
            done_err <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            bit_idx  <= idx_nx;
            shift_q  <= shift_nx;
            done_ok  <= done_ok_nx;
            done_err <= done_err_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        idx_nx      = bit_idx;
        shift_nx    = shift_q;
        done_ok_nx  = 1'b0;
        done_err_nx = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_s != UART_IDLE_LEVEL) begin
                    state_nx = ST_START;
                    cnt_nx   = CNT_START;
                end
            end
            ST_START: begin
                if (!tc) begin
                    cnt_nx = cnt - 1'b1;
                end else if (samp == UART_IDLE_LEVEL) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_DATA;
                    idx_nx   = '0;
                    cnt_nx   = CNT_BIT;
                end
            end
            ST_DATA: begin
                if (!tc) begin
                    cnt_nx = cnt - 1'b1;
                end else begin
                    shift_nx[bit_idx] = samp;
                    cnt_nx            = CNT_BIT;
                    if (bit_idx == LAST_IDX) begin
                        state_nx = ST_STOP;
                    end else begin
                        idx_nx = bit_idx + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (!tc) begin
                    cnt_nx = cnt - 1'b1;
                end else if (samp == UART_IDLE_LEVEL) begin
                    // Returning to IDLE at mid stop bit gives half a bit of slack for the next start.
                    state_nx   = ST_IDLE;
                    done_ok_nx = 1'b1;
                end else begin
                    state_nx    = ST_WAIT_IDLE;
                    done_err_nx = 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_s == UART_IDLE_LEVEL) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    logic [UART_DATA_BITS-1:0] data_q;
    logic                      valid_q;
    logic                      frame_err_q;
    logic                      overrun_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= done_err;
            overrun_q   <= done_ok && valid_q && !rx_bus.ready;
            // A consume in the same cycle frees the slot, so the new byte may land.
            if (done_ok && (!valid_q || rx_bus.ready)) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
            end else if (valid_q && rx_bus.ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_bus.data      = data_q;
    assign rx_bus.valid     = valid_q;
    assign rx_bus.frame_err = frame_err_q;
    assign rx_bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized checks of uart_rx against a frame-timing reference model.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB = 16;
    localparam int HB  = 8;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    // Cycles from first raw-low edge F to the output beat: 2 sync + half bit + 9 bits + 1 register.
    localparam int LAT = 2 + HB + 9 * CPB + 1 + MAJ;

    logic i_clk = 1'b0;
    logic i_rst_n;
    logic i_rx;

    uart_rx_if rx_bus ();

    uart_rx #(.CLK_FREQ(16), .BAUD(1)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_rx    (i_rx),
        .rx_bus  (rx_bus)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] beat_d[$];
    int         beat_c[$];
    int         fe_c[$];
    int         ov_c[$];
    int         vhigh;
    logic       vprev = 1'b0;
    logic [7:0] dprev = 8'h00;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (rx_bus.valid) vhigh++;
            if (rx_bus.valid && rx_bus.ready) begin
                beat_d.push_back(rx_bus.data);
                beat_c.push_back(cyc);
            end
            if (rx_bus.frame_err) fe_c.push_back(cyc);
            if (rx_bus.overrun) ov_c.push_back(cyc);
            if (vprev && rx_bus.valid) begin
                checks++;
                assert (rx_bus.data === dprev) else begin
                    failures++;
                    $error("FAIL data_stable observed=%0h expected=%0h", rx_bus.data, dprev);
                end
            end
            vprev = rx_bus.valid;
            dprev = rx_bus.data;
        end else begin
            vprev = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge i_clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        beat_d.delete();
        beat_c.delete();
        fe_c.delete();
        ov_c.delete();
        vhigh = 0;
    endtask

    // Called one time unit after a rising edge; returns F, the first edge that sees the start bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, output int f);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        f = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            i_rx = bits[i];
            idle(CPB);
        end
    endtask

    int         f1, f2;
    logic [7:0] rb;
    int         gap;
    logic [7:0] exp_d[$];
    int         exp_c[$];

    initial begin
        i_rst_n      = 1'b0;
        i_rx         = 1'b1;
        rx_bus.ready = 1'b1;
        clear_mon();
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_valid", rx_bus.valid, 1'b0);
        chk("rst_data", rx_bus.data, 8'h00);
        chk("rst_frame_err", rx_bus.frame_err, 1'b0);
        chk("rst_overrun", rx_bus.overrun, 1'b0);
        i_rst_n = 1'b1;
        idle(10);
        chk("rst_state", 32'(dut.state), 32'(ST_IDLE));

        // Single frame
        clear_mon();
        send_frame(8'h55, 1'b1, f1);
        idle(30);
        chk("s1_beats", beat_d.size(), 1);
        chk("s1_data", beat_d[0], 8'h55);
        chk("s1_cycle", beat_c[0], f1 + LAT);
        chk("s1_vhigh", vhigh, 1);
        chk("s1_fe", fe_c.size(), 0);
        chk("s1_ov", ov_c.size(), 0);

        // Back-to-back frames, no idle gap
        clear_mon();
        send_frame(8'hA5, 1'b1, f1);
        send_frame(8'h3C, 1'b1, f2);
        idle(30);
        chk("s2_beats", beat_d.size(), 2);
        chk("s2_data0", beat_d[0], 8'hA5);
        chk("s2_data1", beat_d[1], 8'h3C);
        chk("s2_cycle0", beat_c[0], f1 + LAT);
        chk("s2_cycle1", beat_c[1], f2 + LAT);
        chk("s2_fe", fe_c.size(), 0);

        // Short glitch rejected
        clear_mon();
        i_rx = 1'b0;
        idle(4);
        i_rx = 1'b1;
        idle(40);
        chk("s3_beats", beat_d.size(), 0);
        chk("s3_fe", fe_c.size(), 0);
        chk("s3_state", 32'(dut.state), 32'(ST_IDLE));

        // Framing error followed by break, then a good frame
        clear_mon();
        send_frame(8'h81, 1'b0, f1);
        i_rx = 1'b0;
        idle(40);
        i_rx = 1'b1;
        idle(20);
        chk("s4_fe_count", fe_c.size(), 1);
        chk("s4_fe_cycle", fe_c[0], f1 + LAT);
        chk("s4_beats_err", beat_d.size(), 0);
        chk("s4_state", 32'(dut.state), 32'(ST_IDLE));
        send_frame(8'h12, 1'b1, f2);
        idle(30);
        chk("s4_beats", beat_d.size(), 1);
        chk("s4_data", beat_d[0], 8'h12);
        chk("s4_cycle", beat_c[0], f2 + LAT);
        chk("s4_fe_total", fe_c.size(), 1);

        // Overrun while consumer stalls
        clear_mon();
        rx_bus.ready = 1'b0;
        send_frame(8'h11, 1'b1, f1);
        send_frame(8'h22, 1'b1, f2);
        idle(20);
        chk("s5_valid", rx_bus.valid, 1'b1);
        chk("s5_data", rx_bus.data, 8'h11);
        chk("s5_ov_count", ov_c.size(), 1);
        chk("s5_ov_cycle", ov_c[0], f2 + LAT);
        chk("s5_beats_stall", beat_d.size(), 0);
        rx_bus.ready = 1'b1;
        idle(2);
        chk("s5_valid_drop", rx_bus.valid, 1'b0);
        chk("s5_beats", beat_d.size(), 1);
        chk("s5_consumed", beat_d[0], 8'h11);

        // Reset during data bit 3 of 0xF0 (start and bits 0..3 are all low)
        clear_mon();
        i_rx = 1'b0;
        idle(CPB * 4 + HB);
        i_rst_n = 1'b0;
        i_rx    = 1'b1;
        idle(3);
        chk("s6_rst_valid", rx_bus.valid, 1'b0);
        chk("s6_rst_data", rx_bus.data, 8'h00);
        chk("s6_rst_fe", rx_bus.frame_err, 1'b0);
        chk("s6_rst_ov", rx_bus.overrun, 1'b0);
        chk("s6_rst_state", 32'(dut.state), 32'(ST_IDLE));
        i_rst_n = 1'b1;
        idle(40);
        chk("s6_no_partial", beat_d.size(), 0);
        send_frame(8'h0F, 1'b1, f1);
        idle(30);
        chk("s6_beats", beat_d.size(), 1);
        chk("s6_data", beat_d[0], 8'h0F);
        chk("s6_cycle", beat_c[0], f1 + LAT);
        chk("s6_fe", fe_c.size(), 0);

        // Random bytes with random idle gaps (including none)
        clear_mon();
        exp_d.delete();
        exp_c.delete();
        for (int i = 0; i < 10; i++) begin
            rb  = 8'($urandom_range(0, 255));
            gap = int'($urandom_range(0, 20));
            idle(gap);
            send_frame(rb, 1'b1, f1);
            exp_d.push_back(rb);
            exp_c.push_back(f1 + LAT);
        end
        idle(40);
        chk("rnd_beats", beat_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size(); i++) begin
            chk($sformatf("rnd_data%0d", i), beat_d[i], exp_d[i]);
            chk($sformatf("rnd_cycle%0d", i), beat_c[i], exp_c[i]);
        end
        chk("rnd_vhigh", vhigh, exp_d.size());
        chk("rnd_fe", fe_c.size(), 0);
        chk("rnd_ov", ov_c.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
